// File: rtl/cld_pkg.sv
// cld_pkg: state encoding shared by the serial adder controller
package cld_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/m_serial_adder_if.sv
// m_serial_adder_if: operand and result valid/ready handshakes of the serial adder
interface m_serial_adder_if #(parameter int WIDTH = 8);
  logic             w_in_valid;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_out_valid;
  logic             w_out_ready;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  modport master (
    output w_in_valid, w_a, w_b, w_cin, w_out_ready,
    input  w_in_ready, w_out_valid, w_sum, w_cout, w_ovf
  );
  modport slave (
    input  w_in_valid, w_a, w_b, w_cin, w_out_ready,
    output w_in_ready, w_out_valid, w_sum, w_cout, w_ovf
  );
endinterface

// File: rtl/m_serial_adder_fa.sv
// m_FA: 1-bit full-adder cell
module m_FA (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/m_serial_adder.sv
// m_serial_adder: LSB-first bit-serial adder sharing one full-adder cell over WIDTH cycles
module m_serial_adder
  import cld_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic w_clk,
  input  logic w_rst_n,
  m_serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             done;
  m_FA u_fa (
    .i_a(a_q[0]),
    .i_b(b_q[0]),
    .i_c(carry_q),
    .o_s(fa_s),
    .o_c(fa_c)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.w_in_valid) begin
        a_d     = bus.w_a;
        b_d     = bus.w_b;
        carry_d = bus.w_cin;
        sum_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // carry_q here is the carry into the MSB, kept for the overflow flag
        if (cnt_q == CW'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = DONE;
        end
      end
      DONE: state_d = bus.w_out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
    end
  end
  assign done            = state_q == DONE;
  assign bus.w_in_ready  = state_q == IDLE;
  assign bus.w_out_valid = done;
  assign bus.w_sum       = done ? sum_q : '0;
  assign bus.w_cout      = done & carry_q;
  assign bus.w_ovf       = done & (cmsb_q ^ carry_q);
endmodule

// File: tb/tb_m_serial_adder.sv
// tb_m_serial_adder: directed and randomized checks of m_serial_adder against an arithmetic model
module tb_m_serial_adder;
  localparam int W = 8;
  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int nerr = 0;
  int nchk = 0;
  m_serial_adder_if #(.WIDTH(W)) bus ();
  m_serial_adder #(.WIDTH(W)) dut (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(bus));
  always #5 w_clk = ~w_clk;
  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    res_t r;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask
  task automatic wait_valid(input string tag, output int k);
    k = 0;
    while (!bus.w_out_valid && k < 50) begin
      tick();
      k++;
    end
    if (!bus.w_out_valid) check({tag, "_timeout"}, 0, 1);
  endtask
  task automatic check_res(input string tag, input res_t e);
    check({tag, "_valid"}, bus.w_out_valid, 1);
    check({tag, "_sum"}, bus.w_sum, e.sum);
    check({tag, "_cout"}, bus.w_cout, e.cout);
    check({tag, "_ovf"}, bus.w_ovf, e.ovf);
  endtask
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int k;
    k = 0;
    while (!bus.w_in_ready && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_in_ready"}, bus.w_in_ready, 1);
    bus.w_in_valid = 1'b1;
    bus.w_a = a;
    bus.w_b = b;
    bus.w_cin = cin;
    tick();
    bus.w_in_valid = 1'b0;
    wait_valid(tag, k);
    check({tag, "_latency"}, k, W);
    check_res(tag, model(a, b, cin));
    bus.w_out_ready = 1'b1;
    tick();
    bus.w_out_ready = 1'b0;
    check({tag, "_idle"}, bus.w_in_ready, 1);
    check({tag, "_drop"}, bus.w_out_valid, 0);
  endtask
  initial begin
    res_t e, hold;
    res_t q[$];
    int k, acc, got, cyc;
    bus.w_in_valid = 1'b0;
    bus.w_out_ready = 1'b0;
    bus.w_a = '0;
    bus.w_b = '0;
    bus.w_cin = 1'b0;
    tick();
    tick();
    w_rst_n = 1'b1;
    check("rst_in_ready", bus.w_in_ready, 1);
    check("rst_out_valid", bus.w_out_valid, 0);
    check("rst_sum", bus.w_sum, 0);
    check("rst_cout", bus.w_cout, 0);
    check("rst_ovf", bus.w_ovf, 0);
    tick();
    do_op("5a_3c", 8'h5A, 8'h3C, 1'b0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("7f_00_c", 8'h7F, 8'h00, 1'b1);
    do_op("80_80", 8'h80, 8'h80, 1'b0);
    do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1);
    bus.w_in_valid = 1'b1;
    bus.w_a = 8'h33;
    bus.w_b = 8'h44;
    bus.w_cin = 1'b1;
    tick();
    bus.w_in_valid = 1'b0;
    wait_valid("bp", k);
    e = model(8'h33, 8'h44, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_res("bp_hold", e);
      check("bp_in_ready", bus.w_in_ready, 0);
      tick();
    end
    bus.w_out_ready = 1'b1;
    tick();
    bus.w_out_ready = 1'b0;
    check("bp_release", bus.w_in_ready, 1);
    bus.w_in_valid = 1'b1;
    bus.w_a = 8'h12;
    bus.w_b = 8'h34;
    bus.w_cin = 1'b0;
    tick();
    k = 0;
    while (!bus.w_out_valid && k < 50) begin
      bus.w_a = 8'($urandom);
      bus.w_b = 8'($urandom);
      bus.w_cin = 1'($urandom);
      check("hold_in_ready", bus.w_in_ready, 0);
      tick();
      k++;
    end
    check("hold_latency", k, W);
    check_res("hold_first", model(8'h12, 8'h34, 1'b0));
    bus.w_out_ready = 1'b1;
    tick();
    bus.w_out_ready = 1'b0;
    check("hold_idle", bus.w_in_ready, 1);
    bus.w_a = 8'hC8;
    bus.w_b = 8'h64;
    bus.w_cin = 1'b1;
    tick();
    bus.w_in_valid = 1'b0;
    check("hold_accept2", bus.w_in_ready, 0);
    wait_valid("hold2", k);
    check_res("hold_second", model(8'hC8, 8'h64, 1'b1));
    bus.w_out_ready = 1'b1;
    tick();
    bus.w_out_ready = 1'b0;
    bus.w_in_valid = 1'b1;
    bus.w_a = 8'hAA;
    bus.w_b = 8'h55;
    tick();
    bus.w_in_valid = 1'b0;
    repeat (4) tick();
    #2;
    w_rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.w_out_valid, 0);
    check("arst_sum", bus.w_sum, 0);
    check("arst_in_ready", bus.w_in_ready, 1);
    tick();
    #2;
    w_rst_n = 1'b1;
    tick();
    check("arst_no_result", bus.w_out_valid, 0);
    do_op("after_rst", 8'h01, 8'h01, 1'b0);
    acc = 0;
    got = 0;
    cyc = 0;
    while (got < 500 && cyc < 20000) begin
      bus.w_in_valid = acc < 500;
      bus.w_a = 8'($urandom);
      bus.w_b = 8'($urandom);
      bus.w_cin = 1'($urandom);
      bus.w_out_ready = 1'($urandom);
      if (bus.w_in_ready && bus.w_in_valid) begin
        q.push_back(model(bus.w_a, bus.w_b, bus.w_cin));
        acc++;
      end
      if (bus.w_out_valid && bus.w_out_ready) begin
        if (q.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          hold = q.pop_front();
          check("rnd_sum", bus.w_sum, hold.sum);
          check("rnd_cout", bus.w_cout, hold.cout);
          check("rnd_ovf", bus.w_ovf, hold.ovf);
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus.w_in_valid = 1'b0;
    bus.w_out_ready = 1'b0;
    check("rnd_count", got, 500);
    check("rnd_pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/m_serial_adder.md
# m_serial_adder

Bit-serial adder controller: accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake, then sequences a single 1-bit full-adder cell LSB-first over WIDTH cycles. Returns the sum, carry-out and signed-overflow flag through a second valid/ready handshake. Used where area matters more than latency: one full adder is shared across all bit positions under FSM control.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- w_clk  in  1  clock; all state changes on rising edge
- w_rst_n  in  1  asynchronous active-low reset
- w_in_valid  in  1  operands on w_a/w_b/w_cin are valid
- w_in_ready  out  1  block can accept operands
- w_a  in  WIDTH  operand A
- w_b  in  WIDTH  operand B
- w_cin  in  1  carry-in to bit 0
- w_out_valid  out  1  result valid
- w_out_ready  in  1  consumer accepts result
- w_sum  out  WIDTH  sum A+B+cin mod 2^WIDTH
- w_cout  out  1  carry out of MSB
- w_ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: w_in_ready=1. On edge with w_in_valid=1, latch w_a, w_b into shift registers, w_cin into carry register, clear bit counter and sum register -> RUN.
- RUN: each edge, full-adder cell adds A[0], B[0], carry; sum bit shifts into sum register MSB end (register shifts right); carry register <= cell carry-out; A/B shift right; counter +1. On the edge processing bit WIDTH-1, capture the carry register value (carry into MSB) for w_ovf -> DONE.
- DONE: w_out_valid=1; w_sum, w_cout, w_ovf stable while w_out_ready=0. On edge with w_out_ready=1 -> IDLE.
- w_in_ready=0 in RUN and DONE; w_in_valid there is ignored and does not queue.
- Counter width $clog2(WIDTH); no wrap: transition is decoded at count == WIDTH-1.
- Outputs w_sum/w_cout/w_ovf are 0 outside DONE (masked, not raw registers).
- Reset asserted in any state: immediately IDLE, all registers cleared; an in-flight operation is discarded with no result produced.
- Outputs reset values: w_in_ready=1 (IDLE), w_out_valid=0, w_sum=0, w_cout=0, w_ovf=0.

## Timing
- Accept edge = cycle 0. Bit i is computed on edge i+1; DONE entered on edge WIDTH; w_out_valid high from that edge.
- Latency accept-to-valid: WIDTH cycles.
- With w_out_ready held high: DONE lasts 1 cycle, IDLE 1 cycle; max throughput one operation per WIDTH+2 cycles.
- w_in_ready and w_out_valid are pure state decodes (no combinational path from w_in_valid/w_out_ready).
- Input operands sampled only on the accept edge; changes afterward have no effect.

## Structure
- Shared package/header cld_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module: the team's 1-bit full-adder cell m_FA, instantiated once; all sequencing, shift registers and counter in m_serial_adder.
- Single always block for FSM + datapath registers; output masking by continuous assignment.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> w_out_valid exactly 8 cycles after accept, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs constant, in_ready=0; raise out_ready -> IDLE next edge, in_ready=1.
- in_valid held high through RUN with changing a/b -> only first operand pair processed; next accept only after IDLE re-entered.
- Reset asserted 4 cycles into RUN -> out_valid=0, sum=0 immediately (async); after release in_ready=1; new operation 0x01+0x01 -> sum=0x02.
- Back-to-back random operands (≥500, out_ready random) vs. behavioural a+b+cin -> all sum/cout/ovf match; no result lost or duplicated.
